// File: rtl/display_pkg.sv
// Shared types and helpers for the LED matrix scan engine.
// Row r of a frame word occupies DATA[8r+7:8r]; bit c of that byte is column c.
package display_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } scan_state_e;

    localparam int N_ROWS    = 8;
    localparam int N_COLS    = 8;
    localparam int PWM_STEPS = 8;

    function automatic logic [N_COLS-1:0] row_byte(
        input logic [N_ROWS*N_COLS-1:0] frame,
        input logic [2:0]               row
    );
        return frame[row*N_COLS +: N_COLS];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..DIV-1 counter; TICK marks the last count of each period.
// CLR restarts the period so the first tick after a frame load is a full DIV away.
module scan_prescaler #(
    parameter int DIV = 65536
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign TICK = (count == LAST);

endmodule

// File: rtl/matrix_scanner.sv
// Row-multiplexed 8x8 LED scan engine with per-row blanking and 8-step PWM.
// The frame word is captured into a shadow register only in LOAD, so frames never tear.
module matrix_scanner
    import display_pkg::*;
#(
    parameter int DIV         = 65536,
    parameter int BLANK_TICKS = 2,
    parameter bit ROW_ACT_LOW = 1'b0,
    parameter bit COL_ACT_LOW = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_ROWS*N_COLS-1:0] DATA,
    input  logic                     OE,
    input  logic [2:0]               BRIGHT,
    output logic [N_ROWS-1:0]        ROW,
    output logic [N_COLS-1:0]        COLUMN,
    output logic                     CLEAR,
    output logic                     FRAME_STB,
    output scan_state_e              DBG_STATE
);

    localparam int              BW         = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam logic [BW-1:0]   BLANK_LAST = BW'(BLANK_TICKS - 1);
    localparam logic [2:0]      PWM_LAST   = 3'(PWM_STEPS - 1);
    localparam logic [2:0]      ROW_LAST   = 3'(N_ROWS - 1);
    localparam logic [N_ROWS-1:0] ROW_MASK = {N_ROWS{ROW_ACT_LOW}};
    localparam logic [N_COLS-1:0] COL_MASK = {N_COLS{COL_ACT_LOW}};

    scan_state_e               state_q, state_d;
    logic [2:0]                row_q, row_d;
    logic [2:0]                pwm_q, pwm_d;
    logic [BW-1:0]             blank_q, blank_d;
    logic [N_ROWS*N_COLS-1:0]  shadow_q, shadow_d;
    logic [2:0]                bright_q, bright_d;
    logic                      load_clr;
    logic                      tick;

    logic [N_ROWS-1:0]         row_raw;
    logic [N_COLS-1:0]         col_raw;

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (load_clr),
        .TICK (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_LOAD;
            row_q    <= '0;
            pwm_q    <= '0;
            blank_q  <= '0;
            shadow_q <= '0;
            bright_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            pwm_q    <= pwm_d;
            blank_q  <= blank_d;
            shadow_q <= shadow_d;
            bright_q <= bright_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        pwm_d    = pwm_q;
        blank_d  = blank_q;
        shadow_d = shadow_q;
        bright_d = bright_q;
        load_clr = 1'b0;
        case (state_q)
            S_LOAD: begin
                shadow_d = DATA;
                row_d    = '0;
                pwm_d    = '0;
                blank_d  = '0;
                load_clr = 1'b1;
                state_d  = S_BLANK;
            end
            S_BLANK: begin
                if (tick) begin
                    if (blank_q == BLANK_LAST) begin
                        // Brightness is frozen per row so a mid-row change cannot alter on-time.
                        blank_d  = '0;
                        bright_d = BRIGHT;
                        pwm_d    = '0;
                        state_d  = S_ON;
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
            end
            S_ON: begin
                if (tick) begin
                    if (pwm_q == PWM_LAST) begin
                        pwm_d = '0;
                        if (row_q == ROW_LAST) begin
                            // Row returns to 0 here so CLEAR is already high during LOAD.
                            row_d   = '0;
                            state_d = S_LOAD;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = S_BLANK;
                        end
                    end else begin
                        pwm_d = pwm_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_comb begin
        row_raw = '0;
        col_raw = '0;
        if (state_q == S_ON && OE) begin
            row_raw = {{(N_ROWS-1){1'b0}}, 1'b1} << row_q;
            if (pwm_q <= bright_q) begin
                col_raw = row_byte(shadow_q, row_q);
            end
        end
    end

    // Polarity is applied once, right before the pins, so all logic above is active-high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ROW       <= ROW_MASK;
            COLUMN    <= COL_MASK;
            CLEAR     <= 1'b0;
            FRAME_STB <= 1'b0;
        end else begin
            ROW       <= row_raw ^ ROW_MASK;
            COLUMN    <= col_raw ^ COL_MASK;
            CLEAR     <= (row_q == 3'd0);
            FRAME_STB <= (state_q == S_LOAD);
        end
    end

    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// Bench for matrix_scanner: per-cycle expected pin records queued ahead, a negedge monitor pops and compares.
// Instance a runs DIV=4, instance b runs DIV=1; both use BLANK_TICKS=2, active-high rows, active-low columns.
module tb_matrix_scanner;
    import display_pkg::*;

    localparam int BT = 2;
    localparam logic [63:0] D_DIAG = 64'h8040201008040201;
    localparam logic [63:0] D1     = 64'h0123456789ABCDEF;
    localparam logic [63:0] D2     = 64'h81422418C3A55AE7;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_a, rst_b, oe_a, oe_b;
    logic [63:0] data_a, data_b;
    logic [2:0]  bright_a, bright_b;
    logic [7:0]  row_a, row_b, col_a, col_b;
    logic        clr_a, clr_b, stb_a, stb_b;
    scan_state_e dbg_a, dbg_b;

    matrix_scanner #(
        .DIV(4), .BLANK_TICKS(BT), .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b1)
    ) dut_a (
        .CLK(CLK), .RST(rst_a), .DATA(data_a), .OE(oe_a), .BRIGHT(bright_a),
        .ROW(row_a), .COLUMN(col_a), .CLEAR(clr_a), .FRAME_STB(stb_a), .DBG_STATE(dbg_a)
    );

    matrix_scanner #(
        .DIV(1), .BLANK_TICKS(BT), .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b1)
    ) dut_b (
        .CLK(CLK), .RST(rst_b), .DATA(data_b), .OE(oe_b), .BRIGHT(bright_b),
        .ROW(row_b), .COLUMN(col_b), .CLEAR(clr_b), .FRAME_STB(stb_b), .DBG_STATE(dbg_b)
    );

    // Scoreboard: record = {ROW, COLUMN, CLEAR, FRAME_STB} for one output cycle.
    logic [17:0] exp_q[$];
    logic [17:0] mon_e, mon_a;
    logic        sel;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_timeout = 0;
    int          out_idx = 0;
    int          push_budget;
    int          cyc;

    task automatic push_rec(input logic [7:0] r, input logic [7:0] c, input logic clr, input logic stb);
        if (push_budget > 0) begin
            exp_q.push_back({r, c, clr, stb});
            push_budget--;
        end
    endtask

    // Expected pins for one frame starting with the LOAD view, truncated to 'limit' cycles.
    task automatic push_frame(input int dv, input logic [63:0] d, input logic [23:0] br,
                              input logic oe, input int limit);
        logic [7:0] b;
        logic [7:0] onehot;
        logic [2:0] rb;
        logic       first;
        push_budget = limit;
        push_rec(8'h00, 8'hFF, 1'b1, 1'b1);
        for (int r = 0; r < 8; r++) begin
            first  = (r == 0);
            onehot = 8'h01 << r;
            b      = d[8*r +: 8];
            rb     = br[3*r +: 3];
            for (int j = 0; j < BT*dv; j++) push_rec(8'h00, 8'hFF, first, 1'b0);
            for (int k = 0; k < 8; k++) begin
                for (int j = 0; j < dv; j++) begin
                    push_rec(oe ? onehot : 8'h00,
                             (oe && (k <= int'(rb))) ? ~b : 8'hFF, first, 1'b0);
                end
            end
        end
    endtask

    task automatic push_reset_rec();
        exp_q.push_back({8'h00, 8'hFF, 1'b0, 1'b0});
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < budget) begin
            @(posedge CLK);
            i++;
        end
        if (exp_q.size() > 0) begin
            n_timeout++;
            $display("FAIL drain: %0d records still pending after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = sel ? {row_b, col_b, clr_b, stb_b} : {row_a, col_a, clr_a, stb_a};
            n_checks++;
            if (mon_a === mon_e) begin
                n_pass++;
            end else begin
                $display("FAIL pins rec=%0d dut=%s: got row=%h col=%h clear=%b stb=%b, expected row=%h col=%h clear=%b stb=%b",
                         out_idx, sel ? "b" : "a",
                         mon_a[17:10], mon_a[9:2], mon_a[1], mon_a[0],
                         mon_e[17:10], mon_e[9:2], mon_e[1], mon_e[0]);
            end
            out_idx++;
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        oe_a = 1'b1; oe_b = 1'b1;
        data_a = D_DIAG; data_b = '1;
        bright_a = 3'd7; bright_b = 3'd2;
        sel = 1'b0;
        cyc = 0;

        // First frame at DIV=4: diagonal, full brightness, next strobe 321 cycles later.
        repeat (3) @(posedge CLK);
        #1;
        rst_a = 1'b0;
        push_reset_rec();
        push_frame(4, D_DIAG, 24'o77777777, 1'b1, 1000);
        push_frame(4, D_DIAG, 24'o77777777, 1'b1, 1);
        wait_drain(400);

        // DIV=1 run: PWM, tearing, brightness change, OE off, mid-row reset.
        sel = 1'b1;
        @(posedge CLK);
        #1;
        rst_b = 1'b0;
        cyc = 0;
        push_reset_rec();
        push_frame(1, 64'hFFFFFFFFFFFFFFFF, 24'o22222222, 1'b1, 81);
        push_frame(1, D1, 24'o77777777, 1'b1, 81);
        push_frame(1, 64'h0, 24'o77777777, 1'b1, 81);
        push_frame(1, D2, 24'o00000777, 1'b1, 81);
        push_frame(1, D2, 24'o00000000, 1'b0, 81);
        push_frame(1, D2, 24'o33333333, 1'b1, 57);
        push_reset_rec();
        push_frame(1, D2, 24'o33333333, 1'b1, 81);
        push_frame(1, D2, 24'o33333333, 1'b1, 1);

        step_to(1);   data_b = D1;
        step_to(81);  bright_b = 3'd7;
        step_to(112); data_b = 64'h0;
        step_to(170); data_b = D2;
        step_to(267); bright_b = 3'd0;
        step_to(324); oe_b = 1'b0;
        step_to(405); oe_b = 1'b1; bright_b = 3'd3;
        step_to(462); rst_b = 1'b1;
        step_to(463); rst_b = 1'b0;
        wait_drain(300);

        $display("%0d/%0d checks passed", n_pass, n_checks + n_timeout);
        $finish;
    end

endmodule
